// File: rtl/wave_sel_sync_if.sv
// Channel-select bus for wave_sel_sync: sample inputs, switch requests and the
// registered selector outputs. master drives requests, slave is the selector.
interface wave_sel_sync_if #(
  parameter int M = 12,
  parameter int N = 4
);
  localparam int SW = $clog2(N);

  logic [N*M-1:0] in_bus;
  logic           sample_en;
  logic           wrap;
  logic [SW-1:0]  sel_req;
  logic           sel_load;
  logic           force_req;
  logic [M-1:0]   out;
  logic [SW-1:0]  cur_sel;
  logic           pending;

  modport master (
    output in_bus, sample_en, wrap, sel_req, sel_load, force_req,
    input  out, cur_sel, pending
  );

  modport slave (
    input  in_bus, sample_en, wrap, sel_req, sel_load, force_req,
    output out, cur_sel, pending
  );
endinterface

// File: rtl/wave_sel_sync.sv
// Click-free N:1 waveform selector: channel changes wait for a phase wrap,
// a force or a timeout, and the output register loads only on sample_en.
//
// state    | meaning
// ST_IDLE  | no switch waiting, cur_sel is final
// ST_PEND  | pend_sel waiting for wrap / force / timeout
module wave_sel_sync #(
  parameter int M    = 12,
  parameter int N    = 4,
  parameter int TO_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  wave_sel_sync_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam logic [TO_W-1:0] TMR_MAX = '1;

  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   cur_sel, cur_sel_nxt;
  logic [SW-1:0]   pend_sel, pend_sel_nxt;
  logic [TO_W-1:0] tmr, tmr_nxt;
  logic [M-1:0]    out_q;
  logic            sel_ok;
  logic            sel_valid;
  logic            commit;

  // Out-of-range requests only exist when N is not a power of two.
  generate
    if (N == (1 << SW)) begin : g_full
      assign sel_ok = 1'b1;
    end else begin : g_part
      assign sel_ok = (int'(bus.sel_req) < N);
    end
  endgenerate

  assign sel_valid = bus.sel_load && sel_ok;
  assign commit    = (state == ST_PEND) &&
                     (bus.wrap || bus.force_req || (tmr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_sel  <= '0;
      pend_sel <= '0;
      tmr      <= '0;
    end else begin
      state    <= state_nxt;
      cur_sel  <= cur_sel_nxt;
      pend_sel <= pend_sel_nxt;
      tmr      <= tmr_nxt;
    end
  end

  // A valid load always takes priority over a commit in the same cycle.
  always_comb begin
    state_nxt    = state;
    cur_sel_nxt  = cur_sel;
    pend_sel_nxt = pend_sel;
    tmr_nxt      = tmr;
    if (sel_valid) begin
      if (bus.force_req) begin
        cur_sel_nxt = bus.sel_req;
        state_nxt   = ST_IDLE;
      end else if (bus.sel_req == cur_sel) begin
        state_nxt = ST_IDLE;
      end else begin
        pend_sel_nxt = bus.sel_req;
        state_nxt    = ST_PEND;
        tmr_nxt      = TMR_MAX;
      end
    end else if (commit) begin
      cur_sel_nxt = pend_sel;
      state_nxt   = ST_IDLE;
    end else if (state == ST_PEND) begin
      tmr_nxt = tmr - TO_W'(1);
    end
  end

  // Uses the pre-edge cur_sel, so a commit and a sample on one edge keep the old channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (bus.sample_en) begin
      out_q <= bus.in_bus[int'(cur_sel)*M +: M];
    end
  end

  always_comb begin
    bus.out     = out_q;
    bus.cur_sel = cur_sel;
    bus.pending = (state == ST_PEND);
  end
endmodule

// File: tb/tb_wave_sel_sync.sv
// Randomised and directed bench for wave_sel_sync against a rule-level model
// (request age counted up from the load edge), plus a small N=3 build.
module tb_wave_sel_sync;
  localparam int M    = 12;
  localparam int N    = 4;
  localparam int TO_W = 8;
  localparam int TO   = 1 << TO_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wave_sel_sync_if #(.M(M), .N(N)) bus ();
  wave_sel_sync_if #(.M(M), .N(3)) bus3 ();

  wave_sel_sync #(.M(M), .N(N), .TO_W(TO_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  wave_sel_sync #(.M(M), .N(3), .TO_W(4)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // model state
  int           m_cur, m_pend_sel, m_age;
  bit           m_pending;
  logic [M-1:0] m_out;

  task automatic chk_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = 0; m_pend_sel = 0; m_age = 0; m_pending = 0; m_out = '0;
  endtask

  task automatic model_step();
    logic [N*M-1:0] bus_v;
    int req;
    bus_v = bus.in_bus;
    req   = int'(bus.sel_req);
    if (bus.sample_en) m_out = bus_v[m_cur*M +: M];
    if (bus.sel_load && req < N) begin
      if (bus.force_req) begin
        m_cur = req; m_pending = 0;
      end else if (req == m_cur) begin
        m_pending = 0;
      end else begin
        m_pend_sel = req; m_pending = 1; m_age = 0;
      end
    end else if (m_pending) begin
      if (bus.wrap || bus.force_req || m_age == TO - 1) begin
        m_cur = m_pend_sel; m_pending = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk_val({tag, ".out"}, 48'(bus.out), 48'(m_out));
    chk_val({tag, ".cur_sel"}, 48'(bus.cur_sel), 48'(m_cur));
    chk_val({tag, ".pending"}, 48'(bus.pending), 48'(m_pending));
  endtask

  task automatic drive_idle();
    bus.sample_en = 1'b0; bus.wrap = 1'b0; bus.sel_load = 1'b0; bus.force_req = 1'b0;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
    drive_idle();
  endtask

  task automatic load(input int req, input bit frc, input bit wr);
    bus.sel_req = 2'(req); bus.sel_load = 1'b1; bus.force_req = frc; bus.wrap = wr;
  endtask

  initial begin
    bus.in_bus = '0; bus.sel_req = '0;
    drive_idle();
    bus3.in_bus = {12'h333, 12'h222, 12'h111};
    bus3.sample_en = 1'b0; bus3.wrap = 1'b0; bus3.sel_load = 1'b0;
    bus3.force_req = 1'b0; bus3.sel_req = '0;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    check_all("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_all("rst_rel");

    // pass-through and hold
    bus.in_bus = {12'h444, 12'h333, 12'h222, 12'h111};
    bus.sample_en = 1'b1;
    tick("pass");
    chk_val("pass_out", 48'(bus.out), 48'h111);
    bus.in_bus = {12'hddd, 12'hccc, 12'hbbb, 12'haaa};
    tick("hold");
    chk_val("hold_out", 48'(bus.out), 48'h111);
    bus.in_bus = {12'h444, 12'h333, 12'h222, 12'h111};

    // deferred switch at wrap 10 clocks after the load
    load(2, 0, 0);
    tick("defer_ld");
    for (int i = 1; i < 10; i++) begin
      if (i == 3) bus.sample_en = 1'b1;
      tick("defer_wait");
      chk_val("defer_pend", 48'(bus.pending), 48'h1);
    end
    chk_val("defer_early_out", 48'(bus.out), 48'h111);
    bus.wrap = 1'b1;
    tick("defer_wrap");
    chk_val("defer_cur", 48'(bus.cur_sel), 48'h2);
    bus.sample_en = 1'b1;
    tick("defer_smp");
    chk_val("defer_out", 48'(bus.out), 48'h333);

    // timeout on the 256th edge after the load edge
    load(3, 0, 0);
    tick("to_ld");
    for (int i = 1; i < TO; i++) tick("to_wait");
    chk_val("to_pend_255", 48'(bus.pending), 48'h1);
    chk_val("to_cur_255", 48'(bus.cur_sel), 48'h2);
    tick("to_hit");
    chk_val("to_cur_256", 48'(bus.cur_sel), 48'h3);
    chk_val("to_pend_256", 48'(bus.pending), 48'h0);

    // load + force commits directly
    load(1, 1, 0);
    tick("force");
    chk_val("force_cur", 48'(bus.cur_sel), 48'h1);
    chk_val("force_pend", 48'(bus.pending), 48'h0);

    // load + wrap: load wins, no commit
    load(2, 0, 1);
    tick("ldwrap");
    chk_val("ldwrap_pend", 48'(bus.pending), 48'h1);
    chk_val("ldwrap_cur", 48'(bus.cur_sel), 48'h1);
    bus.wrap = 1'b1;
    tick("ldwrap_commit");

    // same-channel request while idle
    load(2, 0, 0);
    tick("same");
    chk_val("same_pend", 48'(bus.pending), 48'h0);

    // reload restarts the timeout
    load(0, 0, 0);
    tick("rl_first");
    repeat (100) tick("rl_wait1");
    load(3, 0, 0);
    tick("rl_second");
    for (int i = 1; i < TO; i++) tick("rl_wait2");
    chk_val("rl_pend_255", 48'(bus.pending), 48'h1);
    tick("rl_hit");
    chk_val("rl_cur", 48'(bus.cur_sel), 48'h3);

    // cancel by loading the current channel while pending
    load(1, 0, 0);
    tick("cn_ld");
    load(3, 0, 0);
    tick("cn_cancel");
    chk_val("cn_pend", 48'(bus.pending), 48'h0);
    chk_val("cn_cur", 48'(bus.cur_sel), 48'h3);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bus.in_bus    = {$urandom, $urandom};
      bus.sample_en = $urandom_range(0, 1) == 1;
      bus.wrap      = $urandom_range(0, (i < 1500) ? 15 : 300) == 0;
      bus.sel_load  = $urandom_range(0, (i < 1500) ? 5 : 400) == 0;
      bus.force_req = $urandom_range(0, 31) == 0;
      bus.sel_req   = 2'($urandom_range(0, N - 1));
      tick("rnd");
    end

    // asynchronous reset mid-cycle while pending
    load((m_cur == 0) ? 1 : 0, 0, 0);
    bus.sample_en = 1'b1;
    tick("mr_ld");
    chk_val("mr_pend_before", 48'(bus.pending), 48'h1);
    @(posedge clk);
    model_step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mr_async");
    bus.in_bus = {12'h444, 12'h333, 12'h222, 12'h111};
    bus.sample_en = 1'b1; bus.wrap = 1'b1;
    @(negedge clk);
    check_all("mr_hold");
    #1 rst_n = 1'b1;
    #2 check_all("mr_rel");
    drive_idle();
    bus.sample_en = 1'b1;
    tick("mr_first");
    chk_val("mr_out", 48'(bus.out), 48'h111);
    chk_val("mr_cur", 48'(bus.cur_sel), 48'h0);

    // N=3 build: sel_req=3 is out of range
    @(negedge clk);
    bus3.sel_req = 2'd3; bus3.sel_load = 1'b1;
    @(negedge clk);
    bus3.sel_load = 1'b0;
    chk_val("n3_oob_pend", 48'(bus3.pending), 48'h0);
    chk_val("n3_oob_cur", 48'(bus3.cur_sel), 48'h0);
    bus3.sel_req = 2'd2; bus3.sel_load = 1'b1;
    @(negedge clk);
    bus3.sel_load = 1'b0;
    chk_val("n3_ld_pend", 48'(bus3.pending), 48'h1);
    bus3.sel_req = 2'd3; bus3.sel_load = 1'b1;
    @(negedge clk);
    bus3.sel_load = 1'b0;
    chk_val("n3_oob2_pend", 48'(bus3.pending), 48'h1);
    bus3.wrap = 1'b1;
    @(negedge clk);
    bus3.wrap = 1'b0;
    chk_val("n3_commit_cur", 48'(bus3.cur_sel), 48'h2);
    chk_val("n3_commit_pend", 48'(bus3.pending), 48'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/wave_sel_sync.md
Name: wave_sel_sync

Overview:
N-channel, M-bit registered waveform selector for the DDS output path. It replaces the plain 2:1 combinational select with a clocked, click-free switch. A channel-change request is held pending and committed only at a phase-accumulator wrap, on a force, or after a timeout. The output register updates only on the sample strobe, so the selector sits between the waveform generators and the DAC/PWM stage.

Parameters:
M, 12, sample width per channel
N, 4, number of input channels (N >= 2); SW = $clog2(N) is a localparam, not overridable
TO_W, 8, timeout counter width; a pending switch is forced after 2^TO_W clocks

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_bus  input  N*M  packed channel samples; channel k = in_bus[k*M +: M]
sample_en  input  1  output sample strobe; out loads only when high
wrap  input  1  phase-accumulator wrap pulse, one clk wide
sel_req  input  SW  requested channel
sel_load  input  1  strobe that captures sel_req
force  input  1  commit pending/requested switch immediately
out  output  M  registered selected sample
cur_sel  output  SW  channel currently driving out
pending  output  1  high while a switch is waiting to commit

Behaviour:
- Reset (rst_n low, asynchronous): out=0, cur_sel=0, pending=0, internal pend_sel=0, cnt=0. Everything holds until the first rising edge after rst_n deasserts.
- Request capture (sel_load=1, sel_req < N):
  - if sel_req == cur_sel and pending=0: ignored, no state change.
  - otherwise: pend_sel<=sel_req, pending<=1, cnt<=0. A new load while pending overwrites pend_sel and restarts cnt. A load equal to cur_sel while pending cancels: pending<=0.
- sel_req >= N with sel_load: ignored entirely, and existing pending state is untouched.
- Commit condition, evaluated each cycle with pending=1 and no sel_load: wrap=1 OR force=1 OR cnt == 2^TO_W-1.
  - On commit: cur_sel<=pend_sel, pending<=0, cnt<=0.
- cnt increments by 1 every clk while pending=1 and no commit occurs. It cannot pass 2^TO_W-1 because the timeout commits at that value. This gives a timeout commit on the 2^TO_W-th rising edge after the edge that captured sel_load.
- Simultaneous events:
  - sel_load and force together with a valid sel_req: cur_sel<=sel_req directly, pending<=0.
  - sel_load and wrap together without force: the load wins, the request becomes pending, and no commit happens that cycle.
  - wrap with pending=0: no effect.
- Output path: on a rising edge with sample_en=1, out <= channel[cur_sel] using the pre-edge cur_sel. With sample_en=0, out holds.
  - A commit at edge E affects out at the first sample_en edge after E.
  - A commit and sample_en on the same edge: out takes the old channel.
- Latency: one clk from in_bus to out, gated by sample_en.
- cur_sel and pending are registered and glitch-free. out never mixes bits from two channels.
- Reset mid-pending: the pending request is discarded, cur_sel=0, out=0.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> out=0, cur_sel=0, pending=0 immediately; no change until the first edge after release.
- Pass-through: N=4, M=12, channels = 0x111/0x222/0x333/0x444, cur_sel=0. Pulse sample_en -> out=0x111 after 1 edge; hold sample_en low and change in_bus -> out stays 0x111.
- Deferred switch: sel_load with sel_req=2, then wrap 10 clks later -> pending=1 for those 10 clks, cur_sel=2 after the wrap edge, next sample_en gives out=0x333. An earlier sample_en gives 0x111.
- Timeout (TO_W=8): sel_load sel_req=3 and no wrap -> cur_sel=3 exactly on the 256th edge after the load edge; pending drops on the same edge.
- Force and priority:
  - sel_load=1, force=1, sel_req=1 -> cur_sel=1 next edge, pending=0.
  - sel_load with sel_req=2 in the same cycle as wrap -> pending=1, cur_sel unchanged.
- Edge requests:
  - sel_req=cur_sel with nothing pending -> no pending.
  - re-load while pending -> pend_sel overwritten and cnt restarted (timeout measured from the second load).
  - sel_req >= N (N=3 build, sel_req=3) -> ignored.
  - reset while pending -> request lost.
